// File: rtl/bar_decoder_pkg.sv
// Shared types and helpers for the bar-graph loopback decoder.
// Optional error counter build macro: BAR_DECODER_ERRCNT_EN (used in bar_decoder.sv).
package bar_decoder_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] BAR_LIT1 = 8'h80;
  localparam logic [7:0] BAR_LIT2 = 8'hC0;
  localparam logic [7:0] BAR_LIT3 = 8'hE0;
  localparam logic [7:0] BAR_LIT4 = 8'hF0;
  localparam logic [7:0] BAR_LIT5 = 8'hF8;
  localparam logic [7:0] BAR_LIT6 = 8'hFC;
  localparam logic [7:0] BAR_LIT7 = 8'hFE;
  localparam logic [7:0] BAR_LIT8 = 8'hFF;

  // Element [n] holds the pattern with n+1 lit segments.
  localparam logic [7:0][7:0] BAR_PATTERNS = {
    BAR_LIT8, BAR_LIT7, BAR_LIT6, BAR_LIT5,
    BAR_LIT4, BAR_LIT3, BAR_LIT2, BAR_LIT1
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] cnt;
  } pair_t;

  // Counts 0..7 light k+1 segments, counts 8..15 light 16-k segments.
  function automatic logic [7:0] bar_of(input logic [3:0] k);
    logic [2:0] idx;
    idx = k[3] ? 3'(4'd15 - k) : k[2:0];
    return BAR_PATTERNS[idx];
  endfunction

  // Resolves the source count from two consecutive lit lengths; 16-l wraps to -l in 4 bits.
  function automatic pair_t pair_cnt(input logic [3:0] p, input logic [3:0] l);
    pair_t r;
    r.valid = 1'b0;
    r.cnt   = 4'd0;
    if (l == p + 4'd1) begin
      r.valid = 1'b1;
      r.cnt   = l - 4'd1;
    end else if (l + 4'd1 == p) begin
      r.valid = 1'b1;
      r.cnt   = 4'd0 - l;
    end else if ((l == p) && (l == 4'd8)) begin
      r.valid = 1'b1;
      r.cnt   = 4'd8;
    end else if ((l == p) && (l == 4'd1)) begin
      r.valid = 1'b1;
      r.cnt   = 4'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bar_decoder_classify.sv
// Combinational legality check of one bar sample; reports its lit length.
module bar_classify
  import bar_decoder_pkg::*;
(
  input  logic [7:0] i_bar,
  output logic       o_legal,
  output logic [3:0] o_level
);

  always_comb begin
    o_legal = 1'b0;
    o_level = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_bar == BAR_PATTERNS[i]) begin
        o_legal = 1'b1;
        o_level = 4'(i + 1);
      end
    end
  end

endmodule

// File: rtl/bar_decoder.sv
// Bar-graph receive decoder: validates samples, recovers the 0..15 count and locks on.
// Define BAR_DECODER_ERRCNT_EN to build the saturating err_total counter; otherwise it reads 0.
module bar_decoder
  import bar_decoder_pkg::*;
#(
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  input  logic [7:0]           bar,
  output logic                 out_valid,
  output logic [3:0]           cnt,
  output logic [3:0]           level,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_total
);

  localparam logic [2:0] LOCK_RUN = 3'(LOCK_CNT);

  state_t     r_state;
  logic       r_known;
  logic [2:0] r_run;
  logic [3:0] r_ref;
  logic [3:0] r_cnt;
  logic [3:0] r_level;
  logic       r_out_valid;
  logic       r_err;

  state_t     w_state_nxt;
  logic       w_known_nxt;
  logic [2:0] w_run_nxt;
  logic [3:0] w_ref_nxt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_level_nxt;
  logic       w_out_valid_nxt;
  logic       w_err_nxt;

  logic       w_legal;
  logic [3:0] w_bar_level;
  logic [3:0] w_pred;
  logic       w_match;
  logic [2:0] w_run_inc;
  pair_t      w_pair;

  bar_classify u_classify (
    .i_bar   (bar),
    .o_legal (w_legal),
    .o_level (w_bar_level)
  );

  assign w_pred    = r_cnt + 4'd1;
  assign w_match   = (bar == bar_of(w_pred));
  assign w_run_inc = r_run + 3'd1;
  assign w_pair    = pair_cnt(r_ref, w_bar_level);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= HUNT;
      r_known     <= 1'b0;
      r_run       <= 3'd0;
      r_ref       <= 4'd0;
      r_cnt       <= 4'd0;
      r_level     <= 4'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_known     <= w_known_nxt;
      r_run       <= w_run_nxt;
      r_ref       <= w_ref_nxt;
      r_cnt       <= w_cnt_nxt;
      r_level     <= w_level_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Every legal sample seen while the count is unknown becomes the new pairing reference.
  always_comb begin
    w_state_nxt     = r_state;
    w_known_nxt     = r_known;
    w_run_nxt       = r_run;
    w_ref_nxt       = r_ref;
    w_cnt_nxt       = r_cnt;
    w_level_nxt     = r_level;
    w_out_valid_nxt = 1'b0;
    w_err_nxt       = 1'b0;
    if (in_valid) begin
      if (w_legal) begin
        w_level_nxt = w_bar_level;
      end
      unique case (r_state)
        HUNT: begin
          if (w_legal) begin
            w_state_nxt = ACQ;
            w_ref_nxt   = w_bar_level;
            w_known_nxt = 1'b0;
            w_run_nxt   = 3'd0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        ACQ: begin
          if (!w_legal) begin
            w_state_nxt = HUNT;
            w_err_nxt   = 1'b1;
            w_known_nxt = 1'b0;
            w_run_nxt   = 3'd0;
          end else if (!r_known) begin
            w_ref_nxt = w_bar_level;
            if (w_pair.valid) begin
              w_cnt_nxt   = w_pair.cnt;
              w_known_nxt = 1'b1;
              w_run_nxt   = 3'd1;
              if (3'd1 >= LOCK_RUN) begin
                w_state_nxt     = LOCKED;
                w_out_valid_nxt = 1'b1;
              end
            end
          end else if (w_match) begin
            w_cnt_nxt = w_pred;
            w_run_nxt = w_run_inc;
            w_ref_nxt = w_bar_level;
            if (w_run_inc >= LOCK_RUN) begin
              w_state_nxt     = LOCKED;
              w_out_valid_nxt = 1'b1;
            end
          end else begin
            w_known_nxt = 1'b0;
            w_run_nxt   = 3'd0;
            w_ref_nxt   = w_bar_level;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_out_valid_nxt = 1'b1;
            w_cnt_nxt       = w_pred;
            w_ref_nxt       = w_bar_level;
          end else begin
            w_err_nxt   = 1'b1;
            w_known_nxt = 1'b0;
            w_run_nxt   = 3'd0;
            if (w_legal) begin
              w_state_nxt = ACQ;
              w_ref_nxt   = w_bar_level;
            end else begin
              w_state_nxt = HUNT;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_known_nxt = 1'b0;
          w_run_nxt   = 3'd0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign cnt       = r_cnt;
  assign level     = r_level;
  assign err       = r_err;
  assign locked    = (r_state == LOCKED);

`ifdef BAR_DECODER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_total;

  // Counts alongside the err pulse so both become visible on the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_err_total <= '0;
    end else if (w_err_nxt && (r_err_total != '1)) begin
      r_err_total <= r_err_total + ERR_CNT_W'(1);
    end
  end

  assign err_total = r_err_total;
`else
  assign err_total = '0;
`endif

endmodule

// File: tb/tb_bar_decoder.sv
// Self-checking bench for bar_decoder against a behavioural decoder model.
module tb_bar_decoder;

  localparam int LOCK_CNT  = 2;
  localparam int ERR_CNT_W = 8;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 in_valid = 1'b0;
  logic [7:0]           bar = 8'h00;
  logic                 out_valid;
  logic [3:0]           cnt;
  logic [3:0]           level;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_total;

  int nVectors = 0;
  int nMiscompares = 0;

  // Model state: mode 0 = hunting, 1 = acquiring, 2 = locked.
  int m_mode, m_run, m_ref, m_cnt, m_level, m_errs;
  bit m_known, m_ov, m_err;

  bar_decoder #(.LOCK_CNT(LOCK_CNT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .bar       (bar),
    .out_valid (out_valid),
    .cnt       (cnt),
    .level     (level),
    .locked    (locked),
    .err       (err),
    .err_total (err_total)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(input int lit);
    logic [7:0] ones;
    ones = 8'hFF;
    return ones << (8 - lit);
  endfunction

  function automatic logic [7:0] barOf(input int k);
    return pat((k < 8) ? k + 1 : 16 - k);
  endfunction

  function automatic void modelReset();
    m_mode = 0; m_run = 0; m_ref = 0; m_cnt = 0; m_level = 0; m_errs = 0;
    m_known = 0; m_ov = 0; m_err = 0;
  endfunction

  function automatic void modelStep(input bit v, input logic [7:0] b);
    int lvl, pred, pcnt;
    bit legal, pv, match;
    m_ov = 0;
    m_err = 0;
    if (!v) return;
    lvl   = $countones(b);
    legal = (lvl > 0) && (b == pat(lvl));
    pred  = (m_cnt + 1) % 16;
    match = (b == barOf(pred));
    pv = 1; pcnt = 0;
    if (lvl == m_ref + 1) pcnt = lvl - 1;
    else if (lvl == m_ref - 1) pcnt = 16 - lvl;
    else if (lvl == m_ref && lvl == 8) pcnt = 8;
    else if (lvl == m_ref && lvl == 1) pcnt = 0;
    else pv = 0;
    if (legal) m_level = lvl;
    case (m_mode)
      0: if (legal) begin m_mode = 1; m_ref = lvl; m_known = 0; m_run = 0; end
         else m_err = 1;
      1: if (!legal) begin m_mode = 0; m_err = 1; m_known = 0; m_run = 0; end
         else if (!m_known) begin
           m_ref = lvl;
           if (pv) begin
             m_cnt = pcnt; m_known = 1; m_run = 1;
             if (m_run >= LOCK_CNT) begin m_mode = 2; m_ov = 1; end
           end
         end else if (match) begin
           m_cnt = pred; m_run++; m_ref = lvl;
           if (m_run >= LOCK_CNT) begin m_mode = 2; m_ov = 1; end
         end else begin
           m_known = 0; m_run = 0; m_ref = lvl;
         end
      default: if (match) begin m_ov = 1; m_cnt = pred; m_ref = lvl; end
         else begin
           m_err = 1; m_known = 0; m_run = 0;
           if (legal) begin m_mode = 1; m_ref = lvl; end
           else m_mode = 0;
         end
    endcase
    if (m_err) m_errs++;
  endfunction

  function automatic logic [14:0] expVec();
    return {m_ov, m_err, (m_mode == 2), 4'(m_level), m_ov ? 4'(m_cnt) : 4'h0};
  endfunction

  function automatic logic [14:0] obsVec();
    return {out_valid, err, locked, level, out_valid ? cnt : 4'h0};
  endfunction

  function automatic logic [ERR_CNT_W-1:0] expTotal();
`ifdef BAR_DECODER_ERRCNT_EN
    int sat;
    sat = (1 << ERR_CNT_W) - 1;
    return ERR_CNT_W'((m_errs > sat) ? sat : m_errs);
`else
    return '0;
`endif
  endfunction

  task automatic applyStimulus(input bit v, input logic [7:0] b);
    in_valid = v;
    bar = b;
    modelStep(v, b);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    in_valid = 1'($urandom);
    bar = 8'($urandom);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    in_valid = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    doReset();
    nVectors++;
    if ({out_valid, err, locked, level, cnt} !== 11'd0 || err_total !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_outputs: got ov=%b err=%b lk=%b lvl=%h cnt=%h tot=%h want all 0",
               out_valid, err, locked, level, cnt, err_total);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] seq [16];
    int errSeen;
    seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    errSeen = 0;
    doReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, seq[i % 16]);
      nVectors++;
      if (obsVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL sweep step %0d: got %h want %h", i, obsVec(), expVec());
      end
      if (i == 2) begin
        nVectors++;
        if (!(out_valid === 1'b1 && cnt === 4'd2 && locked === 1'b1)) begin
          nMiscompares++;
          $display("[TB] FAIL sweep_first_lock: got ov=%b cnt=%0d lk=%b want ov=1 cnt=2 lk=1",
                   out_valid, cnt, locked);
        end
      end
      if (i >= 2 && out_valid === 1'b1 && cnt !== 4'((i + 0) % 16)) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL sweep_cnt step %0d: got %0d want %0d", i, cnt, i % 16);
      end
      if (err === 1'b1) errSeen++;
    end
    nVectors++;
    if (errSeen != 0) begin
      nMiscompares++;
      $display("[TB] FAIL sweep_no_err: got %0d err pulses want 0", errSeen);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] seq [10];
    seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hA0, 8'h80, 8'hC0, 8'hE0};
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, seq[i]);
      nVectors++;
      if (obsVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL illegal step %0d: got %h want %h", i, obsVec(), expVec());
      end
    end
    nVectors++;
    if (!(out_valid === 1'b1 && cnt === 4'd2 && locked === 1'b1)) begin
      nMiscompares++;
      $display("[TB] FAIL illegal_relock: got ov=%b cnt=%0d lk=%b want ov=1 cnt=2 lk=1",
               out_valid, cnt, locked);
    end
  endtask

  task automatic test_stuck();
    logic [7:0] seq [12];
    seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
            8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFC};
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, seq[i]);
      nVectors++;
      if (obsVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL stuck step %0d: got %h want %h", i, obsVec(), expVec());
      end
      if (i == 9) begin
        nVectors++;
        if (!(err === 1'b1 && out_valid === 1'b0 && locked === 1'b0)) begin
          nMiscompares++;
          $display("[TB] FAIL stuck_third_ff: got err=%b ov=%b lk=%b want err=1 ov=0 lk=0",
                   err, out_valid, locked);
        end
      end
    end
    nVectors++;
    if (!(out_valid === 1'b1 && cnt === 4'd10)) begin
      nMiscompares++;
      $display("[TB] FAIL stuck_relock: got ov=%b cnt=%0d want ov=1 cnt=10", out_valid, cnt);
    end
  endtask

  task automatic test_midstream();
    logic [7:0] seq [3];
    seq = '{8'hFF, 8'hFE, 8'hFC};
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, seq[i]);
      nVectors++;
      if (obsVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL midstream step %0d: got %h want %h", i, obsVec(), expVec());
      end
    end
    nVectors++;
    if (!(out_valid === 1'b1 && cnt === 4'd10 && locked === 1'b1)) begin
      nMiscompares++;
      $display("[TB] FAIL midstream_lock: got ov=%b cnt=%0d lk=%b want ov=1 cnt=10 lk=1",
               out_valid, cnt, locked);
    end
  endtask

  task automatic test_idle();
    logic [7:0] seq [8];
    bit         vld [8];
    seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hF8};
    vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vld[i], seq[i]);
      nVectors++;
      if (obsVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL idle step %0d: got %h want %h", i, obsVec(), expVec());
      end
    end
    nVectors++;
    if (!(out_valid === 1'b1 && cnt === 4'd4 && err === 1'b0)) begin
      nMiscompares++;
      $display("[TB] FAIL idle_resume: got ov=%b cnt=%0d err=%b want ov=1 cnt=4 err=0",
               out_valid, cnt, err);
    end
  endtask

  task automatic test_reset_locked();
    doReset();
    applyStimulus(1'b1, 8'h80);
    applyStimulus(1'b1, 8'hC0);
    applyStimulus(1'b1, 8'hE0);
    RST_N = 1'b0;
    in_valid = 1'b1;
    bar = 8'hF0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    in_valid = 1'b0;
    modelReset();
    nVectors++;
    if ({out_valid, err, locked, level, cnt} !== 11'd0 || err_total !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_while_locked: got ov=%b err=%b lk=%b lvl=%h cnt=%h tot=%h want all 0",
               out_valid, err, locked, level, cnt, err_total);
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'hA5);
    nVectors++;
    if (err_total !== expTotal()) begin
      nMiscompares++;
      $display("[TB] FAIL err_total_count: got %0d want %0d", err_total, expTotal());
    end
  endtask

  task automatic test_random();
    int k, r;
    logic [7:0] b;
    bit v;
    doReset();
    k = $urandom_range(0, 15);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      v = 1'b1;
      if (r < 75) begin
        b = barOf(k);
        k = (k + 1) % 16;
      end else if (r < 85) begin
        v = 1'b0;
        b = 8'($urandom);
      end else if (r < 93) begin
        b = pat($urandom_range(1, 8));
      end else begin
        b = 8'($urandom);
      end
      applyStimulus(v, b);
      nVectors++;
      if (obsVec() !== expVec() || err_total !== expTotal()) begin
        nMiscompares++;
        $display("[TB] FAIL random step %0d bar=%h: got %h/%0d want %h/%0d",
                 i, b, obsVec(), err_total, expVec(), expTotal());
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_sweep();
    test_illegal();
    test_stuck();
    test_midstream();
    test_idle();
    test_reset_locked();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
